fpmul_host: RTL and testbench

- Initiator/host end of the serial FP-multiplier operand bus.
- Accepts IEEE-754 single-precision operand pairs from upstream over valid/ready.
- Serialises each pair onto the multiplier's shared 32-bit operand bus in the timing slots that follow each multiplier `ready` pulse.
- Captures the returned product, applies zero/NaN fix-ups, and buffers results for downstream over valid/ready.

---
 rtl/fpmul_host_pkg.sv | 28 ++
 rtl/fpmul_result_fifo.sv | 56 +++++
 rtl/fpmul_host.sv | 126 ++++++++++++
 tb/tb_fpmul_host.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_host_pkg.sv
// rtl/fpmul_host_pkg.sv - shared types, slot timing and FP field constants for fpmul_host
package fpmul_host_pkg;

  typedef enum logic [1:0] {
    WAIT_SLOT = 2'd0,
    DRIVE_A   = 2'd1,
    DRIVE_B   = 2'd2,
    HOLD      = 2'd3
  } state_e;

  localparam int OPA_OFFSET      = 1;
  localparam int OPB_OFFSET      = 2;
  localparam int PRODUCT_LATENCY = 12;

  localparam int         EXP_MSB      = 30;
  localparam int         EXP_LSB      = 23;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  // Returns {nan, product}; a zero operand forces a correctly signed zero.
  function automatic logic [32:0] fixup(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] p);
    logic [31:0] r;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) r = {a[31] ^ b[31], 31'd0};
    else r = p;
    return {r[EXP_MSB:EXP_LSB] == EXP_ALL_ONES, r};
  endfunction

endpackage

// File: rtl/fpmul_result_fifo.sv
// rtl/fpmul_result_fifo.sv - result FIFO of {nan, product} entries with occupancy count
module fpmul_result_fifo #(
  parameter int RES_DEPTH = 2,
  localparam int CNT_W = $clog2(RES_DEPTH + 1),
  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [32:0]      push_data,
  input  logic             pop,
  output logic             valid,
  output logic [32:0]      head,
  output logic [CNT_W-1:0] count
);

  logic [32:0]      mem_q [RES_DEPTH];
  logic [32:0]      mem_d [RES_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = next_ptr(wr_q);
    end
    if (pop) rd_d = next_ptr(rd_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign valid = (count_q != '0);
  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/fpmul_host.sv
// rtl/fpmul_host.sv - host end of the serial FP-multiplier operand bus
module fpmul_host
  import fpmul_host_pkg::*;
#(
  parameter int RES_DEPTH = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mul_nreset,
  output logic [31:0] mul_a,
  input  logic        mul_ready,
  input  logic [31:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_product,
  output logic        out_nan,
  output logic        err_timeout
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d, mul_a_q, mul_a_d;
  logic             pending_q, pending_d, err_q, err_d, nreset_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             slot, push, pop, credit;
  logic [32:0]      push_data, head;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W:0]   occ;

  fpmul_result_fifo #(.RES_DEPTH(RES_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .valid     (out_valid),
    .head      (head),
    .count     (res_count)
  );

  assign pop = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    mul_a_d   = mul_a_q;
    pending_d = pending_q;
    err_d     = err_q;
    wd_d      = wd_q;

    slot      = (state_q == WAIT_SLOT) && mul_ready;
    push      = slot && pending_q;
    push_data = fixup(a_q, b_q, mul_product);
    // Occupancy after this cycle's push/pop; issuing reserves one more entry.
    occ       = {1'b0, res_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    credit    = occ < (CNT_W+1)'(RES_DEPTH);
    in_ready  = slot && credit && !reset;

    case (state_q)
      WAIT_SLOT: begin
        if (mul_ready) begin
          pending_d = in_valid && in_ready;
          if (pending_d) begin
            a_d = in_a;
            b_d = in_b;
          end
          mul_a_d = pending_d ? in_a : '0;
          state_d = DRIVE_A;
        end
      end
      DRIVE_A: begin
        mul_a_d = pending_q ? b_q : '0;
        state_d = DRIVE_B;
      end
      DRIVE_B: state_d = HOLD;
      HOLD:    state_d = WAIT_SLOT;
      default: state_d = WAIT_SLOT;
    endcase

    if (mul_ready) begin
      wd_d = '0;
      if (state_q != WAIT_SLOT) err_d = 1'b1;
    end else if (wd_q >= WD_W'(TIMEOUT - 1)) begin
      wd_d  = WD_W'(TIMEOUT);
      err_d = 1'b1;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    nreset_q <= !reset;
    if (reset) begin
      state_q   <= WAIT_SLOT;
      a_q       <= '0;
      b_q       <= '0;
      mul_a_q   <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mul_a_q   <= mul_a_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_nreset  = nreset_q;
  assign err_timeout = err_q;
  assign out_product = head[31:0];
  assign out_nan     = head[32];

endmodule

// File: tb/tb_fpmul_host.sv
// tb/tb_fpmul_host.sv - scoreboard bench for fpmul_host with a behavioural multiplier
module tb_fpmul_host;
  import fpmul_host_pkg::*;

  localparam int RES_DEPTH = 2;
  localparam int TIMEOUT   = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid, in_ready, mul_nreset, mul_ready, out_valid, out_ready, out_nan, err_timeout;
  logic [31:0] in_a, in_b, mul_a, mul_product, out_product;

  fpmul_host #(.RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_nreset(mul_nreset), .mul_a(mul_a),
    .mul_ready(mul_ready), .mul_product(mul_product), .out_valid(out_valid),
    .out_ready(out_ready), .out_product(out_product), .out_nan(out_nan),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  int          errors = 0;
  int          checks = 0;
  int          accepted = 0;
  int          received = 0;
  op_t         src_q[$];
  logic [32:0] exp_q[$];
  bit          stall = 1'b0;
  bit          slot_busy = 1'b0;
  logic [31:0] slot_a = '0, slot_b = '0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Product the stand-in multiplier returns; zero operands give garbage on purpose.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == 32'h7F00_0000 && b == 32'h4000_0000) return 32'h7F80_0001;
    if ((a & 32'h7FFF_FFFF) == 0 || (b & 32'h7FFF_FFFF) == 0) return 32'h7FC0_0000;
    return (a * 32'd2654435761) ^ b;
  endfunction

  function automatic logic [32:0] expected(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    bit is_zero;
    is_zero = ((a & 32'h7FFF_FFFF) == 0) || ((b & 32'h7FFF_FFFF) == 0);
    r = is_zero ? ((a ^ b) & 32'h8000_0000) : mul_model(a, b);
    return {((r >> 23) & 32'hFF) == 32'hFF, r};
  endfunction

  // Multiplier: slot pulse, bus checks and product return every PRODUCT_LATENCY cycles.
  initial begin
    int sp, warm;
    logic [31:0] op_a, op_b;
    sp = -1; warm = 0; op_a = '0; op_b = '0;
    mul_ready = 1'b0; mul_product = '0;
    forever begin
      @(posedge clock); #1;
      mul_ready = 1'b0;
      if (mul_nreset !== 1'b1) begin
        sp = -1; warm = 0;
      end else if (sp < 0) begin
        warm++;
        if (warm == 3) begin mul_ready = 1'b1; sp = 0; end
      end else begin
        sp++;
        if (sp == OPA_OFFSET) begin
          op_a = mul_a;
          check("bus_a", {1'b0, mul_a}, {1'b0, slot_busy ? slot_a : 32'h0});
        end else if (sp >= OPB_OFFSET && sp < PRODUCT_LATENCY) begin
          if (sp == OPB_OFFSET) op_b = mul_a;
          check("bus_b", {1'b0, mul_a}, {1'b0, slot_busy ? slot_b : 32'h0});
        end else if (sp >= PRODUCT_LATENCY && !stall) begin
          mul_ready   = 1'b1;
          mul_product = (mul_a == 0) ? 32'h0 : mul_model(op_a, op_b);
          sp = 0;
        end
      end
    end
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0;
    forever begin
      @(posedge clock); #1;
      if (src_q.size() > 0) begin
        in_valid = 1'b1; in_a = src_q[0].a; in_b = src_q[0].b;
      end else begin
        in_valid = 1'b0; in_a = '0; in_b = '0;
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (mul_ready) begin
        slot_busy = in_valid && in_ready;
        slot_a = in_a;
        slot_b = in_b;
      end
      if (in_ready) check("in_ready_outside_slot", {32'h0, mul_ready}, 33'h1);
      if (in_valid && in_ready) begin
        exp_q.push_back(expected(in_a, in_b));
        void'(src_q.pop_front());
        accepted++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {out_nan, out_product}, 33'h0_0000_0000 ^ {out_nan, ~out_product});
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("out_product", {1'b0, out_product}, {1'b0, e[31:0]});
          check("out_nan", {32'h0, out_nan}, {32'h0, e[32]});
          received++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {32'h0, in_ready}, 33'h0);
    check({tag, "_mul_a"}, {1'b0, mul_a}, 33'h0);
    check({tag, "_mul_nreset"}, {32'h0, mul_nreset}, 33'h0);
    check({tag, "_out_valid"}, {32'h0, out_valid}, 33'h0);
    check({tag, "_out_product"}, {1'b0, out_product}, 33'h0);
    check({tag, "_out_nan"}, {32'h0, out_nan}, 33'h0);
    check({tag, "_err_timeout"}, {32'h0, err_timeout}, 33'h0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clock); n++;
    end
    check({tag, "_drain"}, 33'(src_q.size() + exp_q.size()), 33'h0);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    op_t op;
    op.a = a; op.b = b;
    src_q.push_back(op);
  endtask

  initial begin
    int a0, r0, n;
    logic [31:0] ra, rb;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1 reset = 1'b0;

    send(32'h4000_0000, 32'h4040_0000);
    wait_idle("single", 200);
    check("single_count", 33'(received), 33'd1);

    send(32'h8000_0000, 32'h3F80_0000);
    wait_idle("zero", 200);

    r0 = received;
    repeat (40) @(posedge clock);
    @(negedge clock);
    check("idle_out_valid", {32'h0, out_valid}, 33'h0);
    check("idle_no_results", 33'(received), 33'(r0));

    @(posedge clock); #1 out_ready = 1'b0;
    a0 = accepted;
    for (int i = 0; i < 4; i++) send(32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i));
    repeat (70) @(posedge clock);
    @(negedge clock);
    check("bp_accepted", 33'(accepted - a0), 33'd2);
    check("bp_out_valid", {32'h0, out_valid}, 33'h1);
    @(posedge clock); #1 out_ready = 1'b1;
    wait_idle("bp", 300);
    check("bp_all_accepted", 33'(accepted - a0), 33'd4);

    send(32'h7F00_0000, 32'h4000_0000);
    wait_idle("nan", 200);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:0] = '0;
      if ($urandom_range(0, 7) == 0) rb[30:0] = '0;
      send(ra, rb);
    end
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clock); #1 out_ready = 1'($urandom_range(0, 1)); n++;
    end
    out_ready = 1'b1;
    wait_idle("random", 200);
    @(negedge clock);
    check("no_false_timeout", {32'h0, err_timeout}, 33'h0);

    stall = 1'b1;
    repeat (TIMEOUT + 8) @(posedge clock);
    @(negedge clock);
    check("watchdog", {32'h0, err_timeout}, 33'h1);

    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); @(negedge clock);
    check_reset_outputs("rst_after_wd");
    @(posedge clock); #1 reset = 1'b0; stall = 1'b0;

    a0 = accepted; r0 = received;
    send(32'h4000_0000, 32'h4040_0000);
    n = 0;
    while (accepted == a0 && n < 100) begin @(negedge clock); n++; end
    check("hold_issue", 33'(accepted - a0), 33'd1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clock); @(negedge clock);
    check_reset_outputs("rst_mid_hold");
    @(posedge clock); #1 reset = 1'b0;
    repeat (60) @(posedge clock);
    check("discarded_product", 33'(received), 33'(r0));

    send(32'h7F00_0000, 32'h4000_0000);
    wait_idle("recover", 200);
    check("recover_count", 33'(received), 33'(r0 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
